// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and parity helper for the sequential multiplier
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mult_seq_state_t;

  // Callers cast narrower data up to this width; zero-extension leaves the XOR unchanged.
  localparam int PARITY_MAX_W = 128;

  function automatic logic calc_parity(input logic [PARITY_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/mult_seq_core.sv
// rtl/mult_seq_core.sv - unsigned shift-add magnitude multiplier, one multiplier bit per cycle
module mult_seq_core #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic            run;
  logic [CW-1:0]   bit_cnt;
  logic [PW-1:0]   acc;
  logic [PW-1:0]   mcand_sh;
  logic [WIDTH-1:0] mplier_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      run       <= 1'b0;
      bit_cnt   <= '0;
      acc       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
    end else if (start) begin
      run       <= 1'b1;
      bit_cnt   <= '0;
      acc       <= '0;
      mcand_sh  <= PW'(mcand);
      mplier_sh <= mplier;
    end else if (run) begin
      if (mplier_sh[0]) acc <= acc + mcand_sh;
      mcand_sh  <= mcand_sh << 1;
      mplier_sh <= mplier_sh >> 1;
      bit_cnt   <= bit_cnt + CW'(1);
      if (bit_cnt == LAST) run <= 1'b0;
    end
  end

  // High during the cycle whose closing edge consumes the last multiplier bit.
  assign done    = run && (bit_cnt == LAST);
  assign product = acc;

endmodule

// File: rtl/mult_seq_par.sv
// rtl/mult_seq_par.sv - parity-checked signed req/ack multiplier; MULT_SEQ_ERR_CNT_EN adds err_cnt
module mult_seq_par
  import mult_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     arg_a,
  input  logic                 arg_a_parity,
  input  logic [WIDTH-1:0]     arg_b,
  input  logic                 arg_b_parity,
  input  logic                 req,
  output logic                 ack,
  output logic                 busy,
  output logic [2*WIDTH-1:0]   result,
  output logic                 result_parity,
  output logic                 result_rdy,
  output logic                 arg_parity_error
`ifdef MULT_SEQ_ERR_CNT_EN
  ,output logic [15:0]         err_cnt
`endif
);

  localparam int   PW  = 2 * WIDTH;
  localparam logic ODD = (PARITY_ODD != 0);

  mult_seq_state_t state;
  logic            perr_in, perr_q, neg_q, start, core_done;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [PW-1:0]   core_product, prod_signed;

  assign perr_in = (arg_a_parity != calc_parity(PARITY_MAX_W'(arg_a), ODD)) ||
                   (arg_b_parity != calc_parity(PARITY_MAX_W'(arg_b), ODD));

  // Unsigned WIDTH-bit magnitudes: the most negative operand maps to 2^(WIDTH-1).
  assign mag_a = arg_a[WIDTH-1] ? (~arg_a + WIDTH'(1)) : arg_a;
  assign mag_b = arg_b[WIDTH-1] ? (~arg_b + WIDTH'(1)) : arg_b;

  assign start       = (state == IDLE) && req && !perr_in;
  assign prod_signed = neg_q ? (~core_product + PW'(1)) : core_product;
  assign busy        = (state != IDLE);

  mult_seq_core #(.WIDTH(WIDTH)) u_core (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .mcand   (mag_a),
    .mplier  (mag_b),
    .done    (core_done),
    .product (core_product)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ack              <= 1'b0;
      result           <= '0;
      result_parity    <= 1'b0;
      result_rdy       <= 1'b0;
      arg_parity_error <= 1'b0;
      perr_q           <= 1'b0;
      neg_q            <= 1'b0;
    end else begin
      ack        <= 1'b0;
      result_rdy <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            ack    <= 1'b1;
            perr_q <= perr_in;
            neg_q  <= arg_a[WIDTH-1] ^ arg_b[WIDTH-1];
            state  <= perr_in ? DONE : CALC;
          end
        end
        CALC: begin
          if (core_done) state <= DONE;
        end
        DONE: begin
          result_rdy       <= 1'b1;
          arg_parity_error <= perr_q;
          if (perr_q) begin
            result        <= '0;
            result_parity <= calc_parity('0, ODD);
          end else begin
            result        <= prod_signed;
            result_parity <= calc_parity(PARITY_MAX_W'(prod_signed), ODD);
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MULT_SEQ_ERR_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if ((state == DONE) && perr_q && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mult_seq_par.sv
// tb/tb_mult_seq_par.sv - randomized and directed checks of mult_seq_par against an arithmetic model
module tb_mult_seq_par;
  import mult_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [15:0] arg_a, arg_b;
  logic        arg_a_parity, arg_b_parity, req;
  logic        ack, busy, result_rdy, result_parity, arg_parity_error;
  logic [31:0] result;

  logic [7:0]  a8, b8;
  logic        pa8, pb8, req8;
  logic        ack8, busy8, rdy8, rpar8, perr8;
  logic [15:0] res8;
`ifdef MULT_SEQ_ERR_CNT_EN
  logic [15:0] err_cnt, err_cnt8;
`endif

  int total = 0;
  int bad   = 0;
  int exp_errs = 0;

  mult_seq_par #(.WIDTH(16), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst),
    .arg_a(arg_a), .arg_a_parity(arg_a_parity),
    .arg_b(arg_b), .arg_b_parity(arg_b_parity),
    .req(req), .ack(ack), .busy(busy),
    .result(result), .result_parity(result_parity),
    .result_rdy(result_rdy), .arg_parity_error(arg_parity_error)
`ifdef MULT_SEQ_ERR_CNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  mult_seq_par #(.WIDTH(8), .PARITY_ODD(1)) u_dut8 (
    .clk(clk), .rst(rst),
    .arg_a(a8), .arg_a_parity(pa8),
    .arg_b(b8), .arg_b_parity(pb8),
    .req(req8), .ack(ack8), .busy(busy8),
    .result(res8), .result_parity(rpar8),
    .result_rdy(rdy8), .arg_parity_error(perr8)
`ifdef MULT_SEQ_ERR_CNT_EN
    , .err_cnt(err_cnt8)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h0000;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Reference product: plain signed arithmetic, truncated to 32 bits.
  function automatic logic [31:0] model_prod(input logic [15:0] a, input logic [15:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p[31:0];
  endfunction

  task automatic wait_rdy(output int k);
    k = 0;
    while (!result_rdy && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bad_a, input logic bad_b);
    logic        exp_err;
    logic [31:0] exp_r;
    int          k;
    exp_err = bad_a || bad_b;
    exp_r   = exp_err ? 32'd0 : model_prod(a, b);
    arg_a = a;
    arg_b = b;
    arg_a_parity = calc_parity(128'(a), 1'b0) ^ bad_a;
    arg_b_parity = calc_parity(128'(b), 1'b0) ^ bad_b;
    req = 1'b1;
    @(posedge clk); #1;
    chk("ack", ack, 1);
    chk("busy", busy, 1);
    req = 1'b0;
    arg_a = 16'($urandom);
    arg_b = 16'($urandom);
    wait_rdy(k);
    chk("latency", k, exp_err ? 1 : 17);
    chk("result", result, exp_r);
    chk("result_parity", result_parity, ^exp_r);
    chk("parity_err", arg_parity_error, exp_err);
    if (exp_err) exp_errs++;
`ifdef MULT_SEQ_ERR_CNT_EN
    chk("err_cnt", err_cnt, exp_errs);
`endif
    @(posedge clk); #1;
    chk("rdy_pulse", result_rdy, 0);
    chk("result_held", result, exp_r);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1);
  end

  initial begin
    int k, rdys;
    rst = 1'b1; req = 1'b0; req8 = 1'b0;
    arg_a = '0; arg_b = '0; arg_a_parity = 1'b0; arg_b_parity = 1'b0;
    a8 = '0; b8 = '0; pa8 = 1'b0; pb8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_rpar", result_parity, 0);
    chk("rst_rdy", result_rdy, 0);
    chk("rst_perr", arg_parity_error, 0);
    chk("rst_rpar_odd", rpar8, 0);
    rst = 1'b0;

    do_op(16'd1, 16'd7, 1'b1, 1'b0);
    do_op(16'd3, 16'hFFFB, 1'b0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    do_op(16'h0000, 16'h8000, 1'b0, 1'b0);
    do_op(16'h7FFF, 16'h8000, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++) begin
      do_op(pick(), pick(), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
    end

    // back-to-back: req held high across two operations
    arg_a = 16'd2; arg_b = 16'd2;
    arg_a_parity = calc_parity(128'(arg_a), 1'b0);
    arg_b_parity = calc_parity(128'(arg_b), 1'b0);
    req = 1'b1;
    @(posedge clk); #1;
    chk("b2b_ack1", ack, 1);
    arg_a = 16'd4; arg_b = 16'hFFFC;
    arg_a_parity = calc_parity(128'(arg_a), 1'b0);
    arg_b_parity = calc_parity(128'(arg_b), 1'b0);
    wait_rdy(k);
    chk("b2b_lat1", k, 17);
    chk("b2b_res1", result, 32'd4);
    chk("b2b_idle_gap", busy, 0);
    @(posedge clk); #1;
    chk("b2b_ack2", ack, 1);
    chk("b2b_busy2", busy, 1);
    req = 1'b0;
    wait_rdy(k);
    chk("b2b_lat2", k, 17);
    chk("b2b_res2", result, 32'hFFFF_FFF0);
    @(posedge clk); #1;

    // reset while the core is on multiplier bit 5
    arg_a = 16'd1234; arg_b = 16'd567;
    arg_a_parity = calc_parity(128'(arg_a), 1'b0);
    arg_b_parity = calc_parity(128'(arg_b), 1'b0);
    req = 1'b1;
    @(posedge clk); #1;
    chk("mid_ack", ack, 1);
    req = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_errs = 0;
    chk("mid_busy", busy, 0);
    chk("mid_result", result, 0);
    chk("mid_rdy", result_rdy, 0);
    chk("mid_perr", arg_parity_error, 0);
    rdys = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (result_rdy) rdys++;
    end
    chk("mid_no_rdy", rdys, 0);
    do_op(16'd1234, 16'd567, 1'b0, 1'b0);
    do_op(16'h0001, 16'h0001, 1'b0, 1'b1);

    // WIDTH=8, odd parity instance
    a8 = 8'd127; b8 = 8'h80;
    pa8 = calc_parity(128'(a8), 1'b1);
    pb8 = calc_parity(128'(b8), 1'b1);
    req8 = 1'b1;
    @(posedge clk); #1;
    chk("w8_ack", ack8, 1);
    req8 = 1'b0;
    k = 0;
    while (!rdy8 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("w8_lat", k, 9);
    chk("w8_result", res8, 16'hC080);
    chk("w8_rpar", rpar8, 0);
    chk("w8_perr", perr8, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mult_seq_par.md
Name: mult_seq_par

Overview:
Parametrised, parity-protected signed multiplier core. Generalises the team's 16-bit req/ack multiplier to WIDTH-bit operands, selectable even/odd parity and an iterative shift-add datapath. Sits behind the multiplier BFM as the DUT.
- Accepts one operand pair per req/ack handshake.
- Checks operand parity and reports the result with result_rdy.

Parameters:
- WIDTH, 16, operand width in bits (>=4); result is 2*WIDTH bits.
- PARITY_ODD, 0, 0 = even parity (bit = XOR of data), 1 = odd parity (bit = ~XOR of data).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- arg_a  in  WIDTH  signed operand A.
- arg_a_parity  in  1  parity of arg_a.
- arg_b  in  WIDTH  signed operand B.
- arg_b_parity  in  1  parity of arg_b.
- req  in  1  operation request, level.
- ack  out  1  one-cycle pulse: operands captured.
- busy  out  1  high while not in IDLE.
- result  out  2*WIDTH  signed product, held.
- result_parity  out  1  parity of result per PARITY_ODD, held.
- result_rdy  out  1  one-cycle pulse: result, result_parity and arg_parity_error valid.
- arg_parity_error  out  1  1 if either operand parity is wrong, held.

Behaviour:
- Reset: all outputs 0, state IDLE, internal registers 0. With PARITY_ODD=1 a result_parity of 0 after reset is expected.
- Reset mid-operation: the operation is aborted, no result_rdy is issued, and the block is IDLE in the next cycle.
- States: IDLE, CALC, DONE.
- IDLE, req=1 sampled at edge n:
  - Capture operands and parities.
  - ack=1 during cycle n+1.
  - Parity OK -> CALC, bit counter=0. Parity bad -> DONE.
- CALC:
  - Shift-add on operand magnitudes, one multiplier bit per cycle, WIDTH cycles.
  - On the last bit -> DONE.
  - req is ignored.
- DONE, one cycle:
  - result_rdy=1. result, result_parity and arg_parity_error are updated in this same cycle and held until the next result_rdy.
  - Next state is IDLE.
  - On a parity error: result=0, result_parity = parity of 0, arg_parity_error=1.
- Latency, req sampled at edge n:
  - Good parity: result_rdy at cycle n+WIDTH+2.
  - Bad parity: result_rdy at cycle n+2.
- Handshake:
  - Requester holds operands stable until ack and drops req after it.
  - req still high in IDLE after DONE starts a new operation (back-to-back allowed).
  - A req that is only high while busy is never seen.
- Arithmetic:
  - Full-precision two's complement, no overflow.
  - Magnitudes are WIDTH-bit unsigned, so |-2^(WIDTH-1)| is representable.
  - Product is negated when the operand signs differ.
  - (-2^(W-1))*(-2^(W-1)) = 2^(2W-2).
  - Zero operand gives 0 regardless of sign.

Optional Feature:
- Macro MULT_SEQ_ERR_CNT_EN.
- Defined: adds output err_cnt [15:0]. It increments on each result_rdy with arg_parity_error=1, saturates at 0xFFFF and is cleared only by rst.
- Undefined: no port and no counter logic; all other behaviour is identical.

Decomposition:
- mult_pkg gains:
  - typedef enum mult_seq_state_t {IDLE, CALC, DONE};
  - function calc_parity(data, odd), used by both RTL and bench.
- One sub-module: mult_seq_core. It holds the shift-add magnitude datapath and the bit counter, with start/done ports. The FSM, parity check and output registers stay in the top.

Test Plan:
- WIDTH=16, a=3, b=-5, correct even parities -> ack at n+1; result_rdy at n+18 with result=0xFFFFFFF1, result_parity=1, arg_parity_error=0.
- WIDTH=16, a=b=-32768 -> result=0x40000000, result_parity=1.
- WIDTH=16, a=1 with arg_a_parity=0 -> ack at n+1; result_rdy at n+2 with result=0, arg_parity_error=1, result_parity=0. With MULT_SEQ_ERR_CNT_EN, err_cnt=1.
- WIDTH=8, PARITY_ODD=1, a=127, b=-128 -> result=0xC080, result_parity=0.
- req held high across two operations (2*2 then 4*-4) -> two ack pulses and two result_rdy pulses with results 4 and -16; busy drops for exactly one cycle between them.
- rst asserted in CALC bit 5 -> no result_rdy; all outputs 0 next cycle; a fresh req completes normally.
